// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB requester arbiter.
//   apb_arb_state_e : arbiter FSM state encoding (ARB -> ISSUE -> WAIT -> ARB)
//   *_DEF           : default parameter values used by apb_arbiter
//   CNT_W           : width of the WAIT-cycle counter
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } apb_arb_state_e;

  localparam int NREQ_DEF   = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TMO_DEF    = 16;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search.
//   req    : request vector, one bit per requester
//   last   : index of the requester served most recently
//   winner : first requesting index found searching last+1 upward with wrap
//   valid  : at least one request bit is set
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // i = NREQ wraps back to 'last' itself, so a lone repeat requester still wins.
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last) + i) % NREQ);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Arbitrates NREQ requesters onto a single APB master transfer port.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req/req_write/req_addr/req_wdata : per-requester transfer requests (packed slices)
//   grant, done, rdata, err    : owner one-hot, completion strobe and its results
//   m_start/m_write/m_addr/m_wdata : transfer launch towards the APB master
//   m_ready/m_rdata/m_slverr   : completion from the APB master
//   dbg_state                  : current FSM state for observation
// Handshake: a requester holds req until it sees its done bit for one cycle;
// m_start pulses once per transfer and only m_ready seen in WAIT completes it.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TMO    = TMO_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic                   m_start,
  output logic                   m_write,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_wdata,
  input  logic                   m_ready,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic                   m_slverr,
  output apb_arb_state_e         dbg_state
);

  localparam int IW = $clog2(NREQ);

  apb_arb_state_e    state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

  logic [IW-1:0]     pick_idx;
  logic              pick_valid;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    done      = '0;
    rdata     = '0;
    err       = 1'b0;
    m_start   = 1'b0;

    case (state_q)
      ST_ARB: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d   = NREQ'(1) << pick_idx;
          owner_d   = pick_idx;
          m_write_d = req_write[pick_idx];
          m_addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          m_wdata_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_start = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A real completion takes precedence over a timeout landing in the same cycle.
        if (m_ready) begin
          done    = grant_q;
          rdata   = m_rdata;
          err     = m_slverr;
          grant_d = '0;
          last_d  = owner_q;
          state_d = ST_ARB;
        end else if (cnt_q == CNT_W'(TMO - 1)) begin
          done    = grant_q;
          err     = 1'b1;
          grant_d = '0;
          last_d  = owner_q;
          state_d = ST_ARB;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ARB;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= IW'(NREQ - 1);
      cnt_q     <= '0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign grant     = grant_q;
  assign m_write   = m_write_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter with default parameters.
module tb_apb_arbiter;
  import apb_arb_pkg::*;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;
  localparam int EXP_W  = NREQ + 1 + DATA_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rdata;
  logic                   err;
  logic                   m_start;
  logic                   m_write;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic                   m_ready;
  logic [DATA_W-1:0]      m_rdata;
  logic                   m_slverr;
  apb_arb_state_e         dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected completion record: {done one-hot, err, rdata}
  logic [EXP_W-1:0] exp_q[$];

  apb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .m_start   (m_start),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_slverr  (m_slverr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_ready   = 1'b0;
    m_rdata   = '0;
    m_slverr  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- driver: one full transfer ----------------
  // ready_at: WAIT-cycle index where m_ready is raised (-1 = never, forcing a timeout).
  task automatic do_xfer(input logic [NREQ-1:0] req_mask, input int exp_idx,
                         input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int ready_at,
                         input logic [DATA_W-1:0] rd, input logic slv,
                         input logic issue_ready, input logic drop_mid,
                         input logic drop_after, input string name,
                         output int start_lat);
    logic [NREQ-1:0]   onehot;
    logic              timed_out;
    logic              exp_err;
    logic [DATA_W-1:0] exp_rd;
    logic [EXP_W-1:0]  exp;
    int                exp_c;

    onehot    = NREQ'(1) << exp_idx;
    timed_out = !(ready_at >= 0 && ready_at <= TMO - 1);
    exp_c     = timed_out ? TMO - 1 : ready_at;
    exp_err   = timed_out ? 1'b1 : slv;
    exp_rd    = timed_out ? '0 : rd;
    exp_q.push_back({onehot, exp_err, exp_rd});

    req                                = req_mask;
    req_write[exp_idx]                 = wr;
    req_addr[exp_idx*ADDR_W +: ADDR_W] = addr;
    req_wdata[exp_idx*DATA_W +: DATA_W] = wdata;
    m_ready                            = 1'b0;

    start_lat = 0;
    while (m_start !== 1'b1 && start_lat < 4) begin
      tick();
      start_lat++;
    end
    checks++;
    if (m_start !== 1'b1) begin
      errors++;
      $display("FAIL %s start: m_start=%b required 1 within 4 cycles", name, m_start);
    end
    checks++;
    if (grant !== onehot || m_addr !== addr || m_wdata !== wdata || m_write !== wr) begin
      errors++;
      $display("FAIL %s issue: grant=%b addr=%h wdata=%h wr=%b required %b %h %h %b",
               name, grant, m_addr, m_wdata, m_write, onehot, addr, wdata, wr);
    end
    if (issue_ready) begin
      m_ready = 1'b1;
      #1;
      checks++;
      if (done !== '0) begin
        errors++;
        $display("FAIL %s issue_ready: done=%b required 0000", name, done);
      end
    end
    tick();

    for (int c = 0; c <= exp_c; c++) begin
      if (drop_mid && c == 0) req[exp_idx] = 1'b0;
      m_ready  = (c == ready_at);
      m_rdata  = rd;
      m_slverr = slv;
      #1;
      checks++;
      if (m_addr !== addr || m_wdata !== wdata || m_write !== wr || m_start !== 1'b0) begin
        errors++;
        $display("FAIL %s hold c%0d: addr=%h wdata=%h wr=%b start=%b", name, c, m_addr,
                 m_wdata, m_write, m_start);
      end
      if (c < exp_c) begin
        checks++;
        if (done !== '0) begin
          errors++;
          $display("FAIL %s early_done c%0d: done=%b required 0000", name, c, done);
        end
        tick();
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard: done=%b with empty expected queue", name, done);
        end else begin
          exp = exp_q.pop_front();
          if ({done, err, rdata} !== exp) begin
            errors++;
            $display("FAIL %s completion: done=%b err=%b rdata=%h required %b %b %h", name,
                     done, err, rdata, exp[EXP_W-1 -: NREQ], exp[DATA_W], exp[DATA_W-1:0]);
          end
        end
      end
    end

    if (drop_after) req = '0;
    tick();
    m_ready  = 1'b0;
    m_slverr = 1'b0;
    #1;
    checks++;
    if (done !== '0) begin
      errors++;
      $display("FAIL %s post_done: done=%b required 0000", name, done);
    end
    if (drop_after) begin
      checks++;
      if (grant !== '0 || dbg_state !== ST_ARB) begin
        errors++;
        $display("FAIL %s back_to_arb: grant=%b state=%0d required 0000 %0d", name, grant,
                 dbg_state, ST_ARB);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (grant !== '0 || done !== '0 || m_start !== 1'b0 || m_write !== 1'b0 ||
        m_addr !== '0 || m_wdata !== '0 || rdata !== '0 || err !== 1'b0 ||
        dbg_state !== ST_ARB) begin
      errors++;
      $display("FAIL reset: grant=%b done=%b start=%b wr=%b addr=%h wdata=%h state=%0d",
               grant, done, m_start, m_write, m_addr, m_wdata, dbg_state);
    end
    tick();
    checks++;
    if (grant !== '0 || m_start !== 1'b0 || dbg_state !== ST_ARB) begin
      errors++;
      $display("FAIL idle: grant=%b start=%b state=%0d required 0000 0 %0d", grant, m_start,
               dbg_state, ST_ARB);
    end
  endtask

  task automatic test_single_write();
    int lat;
    do_xfer(4'b0001, 0, 1'b1, 32'h10, 32'hA5, 2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1,
            "single_write", lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL single_write latency: m_start after %0d cycles required 1", lat);
    end
  endtask

  task automatic test_round_robin();
    int lat;
    logic [NREQ-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_write[i]                 = 1'b1;
      req_addr[i*ADDR_W +: ADDR_W] = 32'h100 + 32'(i * 4);
      req_wdata[i*DATA_W +: DATA_W] = 32'hC000 + 32'(i);
    end
    for (int t = 0; t < 5; t++) begin
      int idx;
      idx = (order[t] == 4'b0001) ? 0 : (order[t] == 4'b0010) ? 1 :
            (order[t] == 4'b0100) ? 2 : 3;
      do_xfer(4'b1111, idx, 1'b1, 32'h100 + 32'(idx * 4), 32'hC000 + 32'(idx),
              $urandom_range(0, 3), 32'h0, 1'b0, 1'b0, 1'b0, t == 4, "round_robin", lat);
    end
  endtask

  task automatic test_read_slverr();
    int lat;
    do_xfer(4'b0100, 2, 1'b0, 32'h2000, 32'h0, 1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1,
            "read_slverr", lat);
  endtask

  task automatic test_timeout();
    int lat;
    do_xfer(4'b1000, 3, 1'b0, 32'h3000, 32'h0, -1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1,
            "timeout", lat);
  endtask

  task automatic test_simultaneous();
    int lat;
    do_xfer(4'b0010, 1, 1'b0, 32'h44, 32'h0, TMO - 1, 32'hCAFE0001, 1'b0, 1'b0, 1'b0, 1'b1,
            "ready_at_tmo", lat);
    do_xfer(4'b0001, 0, 1'b1, 32'h48, 32'h5A5A, 3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1,
            "ready_in_issue", lat);
  endtask

  task automatic test_drop_mid();
    int lat;
    do_xfer(4'b0100, 2, 1'b1, 32'h50, 32'h77, $urandom_range(1, 5), 32'h0, 1'b0, 1'b0,
            1'b1, 1'b1, "drop_mid", lat);
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    apply_reset();
    req                           = 4'b0010;
    req_write[1]                  = 1'b1;
    req_addr[ADDR_W +: ADDR_W]    = 32'h60;
    req_wdata[DATA_W +: DATA_W]   = 32'h61;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010 || dbg_state !== ST_WAIT) begin
      errors++;
      $display("FAIL rst_mid pre: grant=%b state=%0d required 0010 %0d", grant, dbg_state,
               ST_WAIT);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (grant !== '0 || m_start !== 1'b0 || done !== '0 || m_addr !== '0 ||
        m_wdata !== '0 || m_write !== 1'b0 || dbg_state !== ST_ARB) begin
      errors++;
      $display("FAIL rst_mid: grant=%b start=%b done=%b addr=%h state=%0d", grant, m_start,
               done, m_addr, dbg_state);
    end
    rst_n = 1'b1;
    req_addr[31:0]  = 32'h70;
    req_wdata[31:0] = 32'h71;
    req_write[0]    = 1'b1;
    do_xfer(4'b0011, 0, 1'b1, 32'h70, 32'h71, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1,
            "rst_mid_next", lat);
  endtask

  // ---------------- main ----------------
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_slverr();
    test_timeout();
    test_simultaneous();
    test_drop_mid();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d expected completions never seen required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter ADDR_W, default 32: APB address width.
REQ-003 Parameter DATA_W, default 32: APB data width.
REQ-004 Parameter TMO, default 16: maximum number of WAIT cycles before a timeout, 2..255.
REQ-005 clk  in  1: single clock; all logic on posedge.
REQ-006 rst_n  in  1: reset, synchronous and active-low.
REQ-007 req  in  NREQ: per-requester transfer request; level, held until that requester's done.
REQ-008 req_write  in  NREQ: per-requester direction, 1 = write.
REQ-009 req_addr  in  NREQ*ADDR_W: per-requester address, packed, requester i at slice i.
REQ-010 req_wdata  in  NREQ*DATA_W: per-requester write data, packed, requester i at slice i.
REQ-011 grant  out  NREQ: one-hot owner of the current transfer; all zero when not owned.
REQ-012 done  out  NREQ: one-cycle completion strobe to the owner.
REQ-013 rdata  out  DATA_W: read data; valid only while done is nonzero.
REQ-014 err  out  1: completion error (slave error or timeout); valid only while done is nonzero.
REQ-015 m_start  out  1: transfer start to the APB master.
REQ-016 m_write  out  1: latched direction to the APB master.
REQ-017 m_addr  out  ADDR_W: latched address to the APB master.
REQ-018 m_wdata  out  DATA_W: latched write data to the APB master.
REQ-019 m_ready  in  1: transfer complete, from the APB master (PREADY in ACCESS).
REQ-020 m_rdata  in  DATA_W: read data from the APB master.
REQ-021 m_slverr  in  1: slave error from the APB master.

Function
REQ-022 The state machine SHALL have three states: ARB, ISSUE and WAIT.
REQ-023 ARB with any req bit high SHALL, at the next edge:
  - pick the winner round-robin, searching from last+1 upward with wrap;
  - register grant one-hot for the winner;
  - latch the winner's write, addr and wdata onto m_write, m_addr and m_wdata;
  - go to ISSUE.
REQ-024 ARB with req all zero SHALL stay in ARB with grant all zero.
REQ-025 ISSUE SHALL drive m_start=1 for exactly one cycle, then go to WAIT unconditionally.
REQ-026 m_ready SHALL be ignored in ARB and ISSUE.
REQ-027 WAIT SHALL count cycles in an 8-bit counter cleared on entry.
REQ-028 WAIT with m_ready=1 SHALL, combinationally in the same cycle:
  - assert done=grant;
  - pass rdata=m_rdata;
  - drive err=m_slverr.
  At the next edge it SHALL set last=winner, clear grant and go to ARB.
REQ-029 WAIT with the counter equal to TMO-1 and m_ready=0 SHALL assert done=grant, err=1 and rdata=0, then go to ARB and update last.
REQ-030 m_ready and timeout in the same cycle SHALL be treated as a normal completion, with err=m_slverr.
REQ-031 Latency: req rising in ARB at edge t gives m_start high during cycle t+1; an m_ready sampled high in cycle k gives done in cycle k, and the next arbitration is no earlier than edge k+1.
REQ-032 A requester dropping req mid-transfer SHALL NOT abort the transfer; done is still pulsed.
REQ-033 m_write, m_addr and m_wdata SHALL hold stable from ISSUE through the end of WAIT.
REQ-034 At most one grant bit and at most one done bit SHALL ever be high.
REQ-035 done outside WAIT SHALL be all zero and rdata/err SHALL be 0.

Reset
REQ-036 rst_n=0 at an edge, including mid-transfer, SHALL force all of the following, with no done pulse for the aborted transfer:
  - state ARB;
  - grant 0 and m_start 0;
  - m_write 0, m_addr 0, m_wdata 0;
  - counter 0;
  - last = NREQ-1, so requester 0 has first priority.

Structure
REQ-037 Package apb_arb_pkg SHALL hold the state enum typedef and the default NREQ, TMO and width constants.
REQ-038 The round-robin search SHALL live in one combinational sub-module, rr_pick (inputs req and last; outputs winner index and a valid flag).
REQ-039 No other sub-modules; implementation target 150-300 lines.

Verification
REQ-040 Single write: req=0001, addr 0x10, wdata 0xA5, m_ready after 2 WAIT cycles -> m_start in cycle 1, done=0001 with err=0, m_addr=0x10 stable until done.
REQ-041 Round-robin: req=1111 held for 4 transfers after reset -> grant order 0001, 0010, 0100, 1000; then 0001 again.
REQ-042 Read with slave error: req=0100 read, m_rdata=0xDEADBEEF with m_slverr=1 -> done=0100, rdata=0xDEADBEEF, err=1.
REQ-043 Timeout: m_ready held 0 with TMO=16 -> done in the 16th WAIT cycle, err=1, rdata=0, back in ARB the next cycle.
REQ-044 Reset mid-WAIT: rst_n low for 1 cycle while grant=0010 -> grant=0, m_start=0, no done; next req=0011 grants 0001 first.
REQ-045 Simultaneous events: m_ready=1 in the TMO-1 cycle with m_slverr=0 -> err=0; m_ready=1 during ISSUE -> ignored, transfer completes only on a later WAIT-cycle m_ready.
